// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: FSM states, payload limit and baud codes shared by the UART frame transmitter
package uart_frame_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, FIN} state_e;

    localparam int MAX_BYTES = 16;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;
    localparam logic [2:0] BAUD_230400 = 3'd5;
    localparam logic [2:0] BAUD_460800 = 3'd6;
    localparam logic [2:0] BAUD_921600 = 3'd7;

    // clock cycles per serial bit, assuming a 50 MHz clk
    function automatic logic [15:0] bit_cycles(input logic [2:0] baud_set);
        case (baud_set)
            BAUD_9600:   bit_cycles = 16'd5208;
            BAUD_19200:  bit_cycles = 16'd2604;
            BAUD_38400:  bit_cycles = 16'd1302;
            BAUD_57600:  bit_cycles = 16'd868;
            BAUD_115200: bit_cycles = 16'd434;
            BAUD_230400: bit_cycles = 16'd217;
            BAUD_460800: bit_cycles = 16'd108;
            default:     bit_cycles = 16'd54;
        endcase
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 byte serializer; one send_en pulse sends data_byte, tx_done pulses in the last stop-bit cycle
module uart_byte_tx
    import uart_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_byte,
    input  logic       send_en,
    input  logic [2:0] baud_set,
    output logic       rs232_tx,
    output logic       tx_done
);

    logic        active_q, active_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [9:0]  shift_q, shift_d;
    logic        bit_end;

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        bit_end  = active_q && (div_q == bit_cycles(baud_set) - 16'd1);
        tx_done  = bit_end && (bit_q == 4'd9);
        if (!active_q) begin
            if (send_en) begin
                active_d = 1'b1;
                shift_d  = {1'b1, data_byte, 1'b0};
                div_d    = '0;
                bit_d    = '0;
            end
        end else if (bit_end) begin
            div_d    = '0;
            bit_d    = bit_q + 4'd1;
            shift_d  = {1'b1, shift_q[9:1]};
            active_d = !tx_done;
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end

    assign rs232_tx = !active_q || shift_q[0];

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: captures a multi-byte payload and sends it as [header] payload [checksum] over uart_byte_tx
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int         NUM_BYTES   = 3,
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [7:0] HEADER_BYTE = 8'h00,
    parameter bit         CHKSUM_EN   = 1'b0,
    parameter bit         LSB_FIRST   = 1'b1,
    parameter logic [2:0] BAUD_SET    = 3'd4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] send_data,
    output logic                   busy,
    output logic                   done,
    output logic [4:0]             byte_idx,
    output logic                   rs232_tx
);

    if (NUM_BYTES < 1 || NUM_BYTES > MAX_BYTES) begin : g_bad_num_bytes
        $error("uart_frame_tx: NUM_BYTES must be 1..%0d", MAX_BYTES);
    end

    localparam logic [4:0] HDR_LEN  = 5'(HEADER_EN);
    localparam logic [4:0] PAY_END  = 5'(NUM_BYTES);
    localparam logic [4:0] LAST_IDX = 5'(int'(HEADER_EN) + NUM_BYTES + int'(CHKSUM_EN) - 1);

    state_e                 state_q, state_d;
    logic [8*MAX_BYTES-1:0] payload_q, payload_d;
    logic [7:0]             chk_q, chk_d;
    logic [4:0]             idx_q, idx_d;
    logic [7:0]             data_byte_q, data_byte_d;
    logic [4:0]             pay_idx;
    logic [3:0]             sel_idx;
    logic                   is_hdr, is_chk;
    logic [7:0]             cur_byte;
    logic                   send_en, tx_done;

    always_comb begin
        pay_idx     = idx_q - HDR_LEN;
        sel_idx     = LSB_FIRST ? pay_idx[3:0] : 4'(NUM_BYTES - 1) - pay_idx[3:0];
        is_hdr      = HEADER_EN && idx_q == 5'd0;
        is_chk      = CHKSUM_EN && pay_idx == PAY_END;
        cur_byte    = is_hdr ? HEADER_BYTE : is_chk ? chk_q : payload_q[{sel_idx, 3'b000} +: 8];
        state_d     = state_q;
        payload_d   = payload_q;
        chk_d       = chk_q;
        idx_d       = idx_q;
        data_byte_d = data_byte_q;
        case (state_q)
            IDLE: if (start) begin
                payload_d = (8*MAX_BYTES)'(send_data);
                chk_d     = '0;
                idx_d     = '0;
                state_d   = LOAD;
            end
            LOAD: begin
                data_byte_d = cur_byte;
                state_d     = SEND;
            end
            SEND: state_d = WAIT;
            WAIT: if (tx_done) begin
                chk_d   = (is_hdr || is_chk) ? chk_q : chk_q + data_byte_q;
                idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 5'd1;
                state_d = (idx_q == LAST_IDX) ? FIN : LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            payload_q   <= '0;
            chk_q       <= '0;
            idx_q       <= '0;
            data_byte_q <= '0;
        end else begin
            state_q     <= state_d;
            payload_q   <= payload_d;
            chk_q       <= chk_d;
            idx_q       <= idx_d;
            data_byte_q <= data_byte_d;
        end
    end

    assign send_en  = state_q == SEND;
    assign busy     = state_q == LOAD || state_q == SEND || state_q == WAIT;
    assign done     = state_q == FIN;
    assign byte_idx = idx_q;

    uart_byte_tx u_byte_tx (
        .clk      (clk),
        .rst      (rst),
        .data_byte(data_byte_q),
        .send_en  (send_en),
        .baud_set (BAUD_SET),
        .rs232_tx (rs232_tx),
        .tx_done  (tx_done)
    );

endmodule
